hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the write-enable and synchronous-clear inputs of the PC register and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, taken-branch flushes, I/D cache-miss stalls and HLT drain; owns the drain FSM and an optional stall-cycle counter.

Parameters:
- REG_W, 4, register-specifier width (16 GPRs; R0 reads as zero).
- CNT_W, 16, stall counter width.
- DRAIN_CYC, 3, cycles for an HLT in ID to reach WB.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  source reg 1 of the instruction in ID.
- id_rt  in  REG_W  source reg 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_halt  in  1  ID instruction is HLT.
- id_br_taken  in  1  branch resolved taken in ID.
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  REG_W  destination of the EX instruction.
- icache_miss  in  1  level; high while the fetch is not ready.
- dcache_miss  in  1  level; high while the MEM access is not ready.
- pc_wren  out  1  PC write enable.
- if_id_wren, if_id_clr  out  1 each  IF/ID control.
- id_ex_wren, id_ex_clr  out  1 each  ID/EX control.
- ex_mem_wren, ex_mem_clr  out  1 each  EX/MEM control.
- mem_wb_wren, mem_wb_clr  out  1 each  MEM/WB control.
- halted  out  1  pipeline fully drained after HLT.
- stall_cnt  out  CNT_W  stall-cycle count (see feature).

Behaviour:
- Enable/clear outputs are combinational from state and inputs. Default in RUN: every wren=1, every clr=0.
- load_use = ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority, highest first; each row states only the overrides:
  - 1 dcache_miss: pc_wren=0, if_id_wren=0, id_ex_wren=0, ex_mem_wren=0, mem_wb_clr=1. This drops every lower condition.
  - 2 load_use: pc_wren=0, if_id_wren=0, id_ex_clr=1 (one bubble). Branch and halt in ID are ignored this cycle and re-evaluated next.
  - 3 id_br_taken: if_id_clr=1, pc_wren=1 (redirect). Applies even when icache_miss=1; the miss is abandoned by the cache.
  - 4 icache_miss: pc_wren=0, if_id_clr=1.
- FSM states:
  - RUN: id_halt with no higher-priority condition -> DRAIN. In that cycle pc_wren=0, if_id_clr=1; drain_cnt loads DRAIN_CYC-1.
  - DRAIN: pc_wren=0, if_id_clr=1 every cycle. drain_cnt decrements only on cycles with dcache_miss=0; dcache_miss still freezes as in row 1. At drain_cnt==0 with dcache_miss=0 -> HALTED. id_halt, load_use and id_br_taken are ignored, since ID holds bubbles.
  - HALTED: all wren=0, all clr=0, halted=1. Sticky until reset.
- halted=0 outside HALTED.
- Reset (rst=0, asynchronous): state=RUN, drain_cnt=0, halted=0, stall_cnt=0. Outputs then follow RUN rules from the current inputs. Reset mid-DRAIN or in HALTED returns to RUN immediately.
- Simultaneous dcache_miss and icache_miss: dcache rule only, so IF/ID holds rather than clears.
- Latency: all hazard responses take effect in the same cycle (0-cycle combinational). State changes occur on the rising clk edge.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each rising edge where pc_wren==0 and state!=HALTED. It saturates at all-ones and is cleared only by reset.
- Undefined: no counter flops; stall_cnt is tied to 0.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_wren=0, if_id_wren=0, id_ex_clr=1. Next cycle with ex_memread=0 -> all wren=1, all clr=0. Repeat with ex_rd=0 -> no stall.
- Branch during icache miss: id_br_taken=1, icache_miss=1 -> pc_wren=1, if_id_clr=1. Add dcache_miss=1 -> pc_wren=0, if_id_wren=0, if_id_clr=0, mem_wb_clr=1.
- Dcache stall: dcache_miss=1 for 4 cycles with load_use true -> EX/MEM and earlier stages frozen all 4 cycles, mem_wb_clr=1, id_ex_clr=0. With the macro defined, stall_cnt=4.
- Halt drain: id_halt=1 in RUN, with dcache_miss=1 for 2 cycles inserted mid-drain -> halted rises exactly 5 edges after the HLT cycle (3 drain + 2 frozen). Then all wren=0. pc_wren=0 throughout the drain.
- Reset in DRAIN and in HALTED: rst=0 asynchronously -> halted=0 without a clock edge, stall_cnt=0, outputs follow RUN defaults after release.
- Counter saturation with the macro defined and CNT_W=4: hold icache_miss=1 for 20 cycles -> stall_cnt=15 and stays there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: hazard priority, HLT drain FSM.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int REG_W     = 4,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic             id_br_taken,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    output logic             pc_wren,
    output logic             if_id_wren,
    output logic             if_id_clr,
    output logic             id_ex_wren,
    output logic             id_ex_clr,
    output logic             ex_mem_wren,
    output logic             ex_mem_clr,
    output logic             mem_wb_wren,
    output logic             mem_wb_clr,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYC - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_nxt;
    logic          load_use;

    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    // Hazard priority resolution and drain FSM next-state logic.
    always_comb begin
        pc_wren     = 1'b1;
        if_id_wren  = 1'b1;
        if_id_clr   = 1'b0;
        id_ex_wren  = 1'b1;
        id_ex_clr   = 1'b0;
        ex_mem_wren = 1'b1;
        ex_mem_clr  = 1'b0;
        mem_wb_wren = 1'b1;
        mem_wb_clr  = 1'b0;
        halted      = 1'b0;
        state_nxt   = state;
        drain_nxt   = drain_cnt;
        unique case (state)
            S_DRAIN: begin
                // ID only holds bubbles here, so ID-side hazards are moot.
                pc_wren   = 1'b0;
                if_id_clr = 1'b1;
                if (dcache_miss) begin
                    if_id_wren  = 1'b0;
                    id_ex_wren  = 1'b0;
                    ex_mem_wren = 1'b0;
                    mem_wb_clr  = 1'b1;
                end else if (drain_cnt == '0) begin
                    state_nxt = S_HALTED;
                end else begin
                    drain_nxt = drain_cnt - DW'(1);
                end
            end
            S_HALTED: begin
                pc_wren     = 1'b0;
                if_id_wren  = 1'b0;
                id_ex_wren  = 1'b0;
                ex_mem_wren = 1'b0;
                mem_wb_wren = 1'b0;
                halted      = 1'b1;
            end
            default: begin
                if (dcache_miss) begin
                    pc_wren     = 1'b0;
                    if_id_wren  = 1'b0;
                    id_ex_wren  = 1'b0;
                    ex_mem_wren = 1'b0;
                    mem_wb_clr  = 1'b1;
                end else if (load_use) begin
                    pc_wren    = 1'b0;
                    if_id_wren = 1'b0;
                    id_ex_clr  = 1'b1;
                end else if (id_br_taken) begin
                    // Redirect wins over a pending fetch miss.
                    if_id_clr = 1'b1;
                end else if (id_halt) begin
                    pc_wren   = 1'b0;
                    if_id_clr = 1'b1;
                    state_nxt = S_DRAIN;
                    drain_nxt = DRAIN_LD;
                end else if (icache_miss) begin
                    pc_wren   = 1'b0;
                    if_id_clr = 1'b1;
                end
            end
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of cycles where the PC is held, excluding HALTED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!pc_wren && state != S_HALTED && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
// Define HAZARD_STALL_CNT_EN to also check the stall counter.
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int CW = 4;

    // {pc, if_id_w, if_id_c, id_ex_w, id_ex_c, ex_mem_w, ex_mem_c, mem_wb_w, mem_wb_c, halted}
    localparam logic [9:0] V_RUN  = 10'b1101010100;
    localparam logic [9:0] V_LU   = 10'b0001110100;
    localparam logic [9:0] V_BR   = 10'b1111010100;
    localparam logic [9:0] V_IM   = 10'b0111010100;
    localparam logic [9:0] V_DM   = 10'b0000000110;
    localparam logic [9:0] V_DRDM = 10'b0010000110;
    localparam logic [9:0] V_HLT  = 10'b0000000001;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, id_halt, id_br_taken;
    logic          ex_memread, icache_miss, dcache_miss;
    logic          pc_wren, if_id_wren, if_id_clr, id_ex_wren, id_ex_clr;
    logic          ex_mem_wren, ex_mem_clr, mem_wb_wren, mem_wb_clr, halted;
    logic [CW-1:0] stall_cnt;

    typedef struct packed {
        logic [9:0]    ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    nchk  = 0;
    int    nfail = 0;
    int    mcnt  = 0;

    hazard_ctrl #(.REG_W(RW), .CNT_W(CW), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .id_br_taken(id_br_taken),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss),
        .pc_wren(pc_wren),
        .if_id_wren(if_id_wren), .if_id_clr(if_id_clr),
        .id_ex_wren(id_ex_wren), .id_ex_clr(id_ex_clr),
        .ex_mem_wren(ex_mem_wren), .ex_mem_clr(ex_mem_clr),
        .mem_wb_wren(mem_wb_wren), .mem_wb_clr(mem_wb_clr),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] exp_cnt();
`ifdef HAZARD_STALL_CNT_EN
        return CW'(mcnt);
`else
        return '0;
`endif
    endfunction

    task automatic si(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                      input logic urs, input logic urt, input logic hlt,
                      input logic br, input logic mr, input logic [RW-1:0] rd,
                      input logic im, input logic dm);
        id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_halt = hlt; id_br_taken = br; ex_memread = mr; ex_rd = rd;
        icache_miss = im; dcache_miss = dm;
    endtask

    task automatic push(input logic [9:0] ctl, input string tag);
        exp_t e;
        e.ctl = ctl;
        e.cnt = exp_cnt();
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(output exp_t e);
        logic [9:0] got;
        string      tag;
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        got = {pc_wren, if_id_wren, if_id_clr, id_ex_wren, id_ex_clr,
               ex_mem_wren, ex_mem_clr, mem_wb_wren, mem_wb_clr, halted};
        nchk++;
        assert (got === e.ctl) else begin
            nfail++;
            $error("FAIL %s ctl: got %b expected %b", tag, got, e.ctl);
        end
        nchk++;
        assert (stall_cnt === e.cnt) else begin
            nfail++;
            $error("FAIL %s stall_cnt: got %0d expected %0d", tag, stall_cnt, e.cnt);
        end
    endtask

    // One clocked cycle: inputs already driven, check mid-cycle, then clock.
    task automatic cyc(input logic [9:0] ctl, input string tag);
        exp_t e;
        push(ctl, tag);
        @(negedge clk);
        pop_check(e);
        if (!e.ctl[9] && !e.ctl[0] && mcnt < (2**CW - 1)) mcnt++;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous check without a clock edge.
    task automatic now(input logic [9:0] ctl, input string tag);
        exp_t e;
        push(ctl, tag);
        #1;
        pop_check(e);
    endtask

    initial begin
        rst = 1'b0;
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        now(V_RUN, "reset");
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        si(5, 0, 1, 0, 0, 0, 1, 5, 0, 0); cyc(V_LU, "lu_rs");
        si(5, 0, 1, 0, 0, 0, 0, 5, 0, 0); cyc(V_RUN, "lu_gone");
        si(0, 0, 1, 0, 0, 0, 1, 0, 0, 0); cyc(V_RUN, "lu_r0");
        si(0, 7, 0, 1, 0, 0, 1, 7, 0, 0); cyc(V_LU, "lu_rt");
        si(0, 7, 0, 0, 0, 0, 1, 7, 0, 0); cyc(V_RUN, "lu_rt_unused");
        si(3, 0, 1, 0, 0, 1, 1, 3, 0, 0); cyc(V_LU, "lu_over_br");

        si(0, 0, 0, 0, 0, 1, 0, 0, 1, 0); cyc(V_BR, "br_imiss");
        si(0, 0, 0, 0, 0, 1, 0, 0, 1, 1); cyc(V_DM, "br_im_dm");
        si(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); cyc(V_IM, "imiss");
        si(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc(V_DM, "im_dm");

        si(5, 0, 1, 0, 0, 0, 1, 5, 0, 1);
        for (int i = 0; i < 4; i++) cyc(V_DM, "dm_lu");
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(V_RUN, "dm_done");

        si(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cyc(V_IM, "hlt_run");
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(V_IM, "drain1");
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); cyc(V_DRDM, "drain_dm1");
        cyc(V_DRDM, "drain_dm2");
        si(5, 0, 1, 0, 1, 1, 1, 5, 0, 0); cyc(V_IM, "drain2");
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(V_IM, "drain3");
        cyc(V_HLT, "halted1");
        si(0, 0, 0, 0, 0, 1, 0, 0, 1, 0); cyc(V_HLT, "halted2");

        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        mcnt = 0;
        now(V_RUN, "rst_halted");
        #1 rst = 1'b1;
        cyc(V_RUN, "run_after_rst1");

        si(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); cyc(V_IM, "hlt_run2");
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(V_IM, "drain_b");
        rst = 1'b0;
        mcnt = 0;
        now(V_RUN, "rst_drain");
        #1 rst = 1'b1;
        cyc(V_RUN, "run_after_rst2");
        cyc(V_RUN, "run_after_rst3");

        si(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) cyc(V_IM, "sat");
        si(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc(V_RUN, "sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
